// File: rtl/imem_loader_pkg.sv
// Shared widths and FSM state encoding for the instruction-memory loader.
package imem_loader_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;
    localparam int LEN_W  = 16;

    typedef enum logic [2:0] {
        LD_IDLE   = 3'd0,
        LD_LEN_HI = 3'd1,
        LD_LEN_LO = 3'd2,
        LD_DATA   = 3'd3,
        LD_CHK    = 3'd4,
        LD_DONE   = 3'd5,
        LD_ERR    = 3'd6
    } ld_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles big-endian bytes into 32-bit words; word_valid pulses
// for one cycle after the fourth byte of each word.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [BYTE_W-1:0] byte_data,
    input  logic              byte_valid,
    output logic [WORD_W-1:0] word,
    output logic              word_valid,
    output logic [1:0]        byte_cnt
);

    logic [23:0] shift;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift      <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            byte_cnt   <= 2'd0;
        end else if (clear) begin
            shift      <= '0;
            word_valid <= 1'b0;
            byte_cnt   <= 2'd0;
        end else begin
            word_valid <= 1'b0;
            if (byte_valid) begin
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    word       <= {shift, byte_data};
                    word_valid <= 1'b1;
                end else begin
                    shift <= {shift[15:0], byte_data};
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed byte stream into inst_mem and holds the CPU
// in reset until done. Optional trailing XOR checksum: IMEM_LOADER_CHKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                MAX_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    ld_state_t         state;
    logic [BYTE_W-1:0] len_hi;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  word_idx;
    logic [LEN_W-1:0]  len_word;
    logic [1:0]        byte_cnt;
    logic              xfer;
    logic              push;
    logic              start_ok;
    logic              last_word;
`ifdef IMEM_LOADER_CHKSUM_EN
    logic [BYTE_W-1:0] chk;
`endif

    assign xfer      = rx_valid & rx_ready;
    assign push      = xfer && (state == LD_DATA);
    assign start_ok  = start && (state inside {LD_IDLE, LD_DONE, LD_ERR});
    assign len_word  = {len_hi, rx_data};
    assign last_word = (word_idx == len - LEN_W'(1));

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_ok),
        .byte_data  (rx_data),
        .byte_valid (push),
        .word       (imem_wdata),
        .word_valid (imem_we),
        .byte_cnt   (byte_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LD_IDLE;
            rx_ready  <= 1'b0;
            imem_addr <= BASE_ADDR;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            len_hi    <= '0;
            len       <= '0;
            word_idx  <= '0;
`ifdef IMEM_LOADER_CHKSUM_EN
            chk       <= '0;
`endif
        end else begin
            case (state)
                LD_IDLE, LD_DONE, LD_ERR: begin
                    if (start) begin
                        state     <= LD_LEN_HI;
                        rx_ready  <= 1'b1;
                        cpu_hold  <= 1'b1;
                        done      <= 1'b0;
                        err       <= 1'b0;
                        word_idx  <= '0;
                        imem_addr <= BASE_ADDR;
`ifdef IMEM_LOADER_CHKSUM_EN
                        chk       <= '0;
`endif
                    end
                end
                LD_LEN_HI: begin
                    if (xfer) begin
                        len_hi <= rx_data;
                        state  <= LD_LEN_LO;
`ifdef IMEM_LOADER_CHKSUM_EN
                        chk    <= chk ^ rx_data;
`endif
                    end
                end
                LD_LEN_LO: begin
                    if (xfer) begin
                        len <= len_word;
`ifdef IMEM_LOADER_CHKSUM_EN
                        chk <= chk ^ rx_data;
`endif
                        if (32'(len_word) > MAX_WORDS) begin
                            state    <= LD_ERR;
                            rx_ready <= 1'b0;
                            err      <= 1'b1;
                        end else if (len_word == '0) begin
`ifdef IMEM_LOADER_CHKSUM_EN
                            state    <= LD_CHK;
`else
                            state    <= LD_DONE;
                            rx_ready <= 1'b0;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
`endif
                        end else begin
                            state <= LD_DATA;
                        end
                    end
                end
                LD_DATA: begin
`ifdef IMEM_LOADER_CHKSUM_EN
                    if (push)
                        chk <= chk ^ rx_data;
`endif
                    // Stall the stream while the final word is written so no trailing byte is absorbed as data.
                    if (push && byte_cnt == 2'd3 && last_word)
                        rx_ready <= 1'b0;
                    if (imem_we) begin
                        word_idx  <= word_idx + LEN_W'(1);
                        imem_addr <= imem_addr + ADDR_W'(4);
                        if (last_word) begin
`ifdef IMEM_LOADER_CHKSUM_EN
                            state    <= LD_CHK;
                            rx_ready <= 1'b1;
`else
                            state    <= LD_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
`endif
                        end
                    end
                end
`ifdef IMEM_LOADER_CHKSUM_EN
                LD_CHK: begin
                    if (xfer) begin
                        rx_ready <= 1'b0;
                        if (rx_data == chk) begin
                            state    <= LD_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= LD_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state    <= LD_IDLE;
                    rx_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a stream-level model queues expected writes,
// a monitor pops them on every imem_we; honours IMEM_LOADER_CHKSUM_EN.
module tb_imem_loader;

    localparam int          MAX_WORDS = 1024;
    localparam logic [31:0] BASE      = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    imem_loader #(.ADDR_W(32), .MAX_WORDS(MAX_WORDS), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] img[$];
    int          checks   = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {31'd0, imem_we}, 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", imem_addr, e.addr);
                check("write_data", imem_wdata, e.data);
            end
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // gap_mode: 0 back-to-back, 1 one idle cycle between bytes, 2 random idle cycles.
    task automatic send_byte(input logic [7:0] b, input int gap_mode);
        if (gap_mode == 1)
            begin @(posedge clk); #1; end
        else if (gap_mode == 2)
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        rx_data  = b;
        rx_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (rx_ready) begin
                @(posedge clk); #1;
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                return;
            end
        end
        check("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
        rx_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
        check({tag, "_imem_we"}, {31'd0, imem_we}, 32'd0);
        check({tag, "_imem_addr"}, imem_addr, BASE);
        check({tag, "_imem_wdata"}, imem_wdata, 32'd0);
        check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    // Builds the stream for n words of img, predicts the writes and the outcome,
    // drives it, then checks the final status. chk_val < 0 sends the correct checksum.
    task automatic run_image(input int n, input int chk_val, input int gap_mode, input bit mid_start);
        logic [7:0] bq[$];
        logic [7:0] x;
        bit         overflow;
        bit         exp_ok;
        int         t;
        wr_t        e;
        bq.push_back(8'(n >> 8));
        bq.push_back(8'(n));
        overflow = (n > MAX_WORDS);
        if (!overflow) begin
            for (int i = 0; i < n; i++) begin
                for (int k = 3; k >= 0; k--)
                    bq.push_back(8'(img[i] >> (8 * k)));
                e.addr = BASE + 32'(4 * i);
                e.data = img[i];
                exp_q.push_back(e);
            end
        end
        x = 8'd0;
        foreach (bq[i]) x = x ^ bq[i];
        exp_ok = !overflow;
`ifdef IMEM_LOADER_CHKSUM_EN
        if (!overflow) begin
            logic [7:0] c;
            c = (chk_val < 0) ? x : 8'(chk_val);
            bq.push_back(c);
            exp_ok = (c == x);
        end
`else
        if (chk_val > 255) exp_ok = 1'b0;
`endif
        pulse_start();
        foreach (bq[i]) begin
            send_byte(bq[i], gap_mode);
            if (mid_start && i == 3) pulse_start();
        end
        t = 0;
        while (!(done || err) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("finish_timeout", {31'd0, done | err}, 32'd1);
        repeat (2) @(negedge clk);
        check("done", {31'd0, done}, {31'd0, exp_ok});
        check("err", {31'd0, err}, {31'd0, !exp_ok});
        check("cpu_hold", {31'd0, cpu_hold}, {31'd0, !exp_ok});
        check("rx_ready_after", {31'd0, rx_ready}, 32'd0);
        check("pending_writes", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        rx_data  = 8'd0;
        rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Two-word image, back-to-back and then with rx_valid toggling.
        img = '{32'h2008_0005, 32'h0000_0008};
        run_image(2, -1, 0, 1'b0);
        run_image(2, -1, 1, 1'b0);

        // Length one past the limit aborts after the length bytes.
        run_image(MAX_WORDS + 1, -1, 0, 1'b0);

`ifdef IMEM_LOADER_CHKSUM_EN
        run_image(2, 0, 0, 1'b0);
`endif

        // Empty image.
        run_image(0, -1, 0, 1'b0);

        // Reset after the second data byte, then a fresh full image.
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h20, 0);
        send_byte(8'h08, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_values("midload_reset");
        rst = 1'b0;
        @(posedge clk); #1;
        img = '{32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF};
        run_image(3, -1, 0, 1'b0);

        // start during a load must be ignored.
        run_image(3, -1, 1, 1'b1);

        // Randomized images, gaps and checksums.
        for (int r = 0; r < 12; r++) begin
            int n;
            int cv;
            n = $urandom_range(0, 8);
            img.delete();
            for (int i = 0; i < n; i++) img.push_back($urandom);
            cv = ($urandom_range(0, 1) == 1) ? -1 : int'($urandom_range(0, 255));
            run_image(n, cv, 2, 1'b0);
        end

        // Largest legal image.
        img.delete();
        for (int i = 0; i < MAX_WORDS; i++) img.push_back($urandom);
        run_image(MAX_WORDS, -1, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
